// File: rtl/ddr3_pg_arbiter.sv
// Round-robin arbiter sharing the DDR3 page-transfer port among N_REQ requesters,
// running 4-phase handshakes on both sides with a bounded wait for pg_ack.
module ddr3_pg_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    calib_done,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_optype,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        ack,
    output logic                    xfer_err,
    output logic [N_REQ-1:0]        grant,
    output logic                    pg_req,
    output logic                    pg_optype,
    output logic [ADDR_W-1:0]       pg_req_addr,
    input  logic                    pg_ack,
    output logic                    busy,
    output logic                    timeout_flag
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

    state_t            state, state_nxt;
    logic              calib_meta, calib_s;
    logic              pg_ack_meta, pg_ack_s;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     last, last_nxt;
    logic [TW-1:0]     timer, timer_nxt, timer_inc;
    logic              xfer_err_r, xfer_err_r_nxt;
    logic [N_REQ-1:0]  ack_nxt, grant_nxt;
    logic              xfer_err_nxt, pg_req_nxt, pg_optype_nxt, busy_nxt, timeout_flag_nxt;
    logic [ADDR_W-1:0] pg_req_addr_nxt;
    logic [IW-1:0]     win, cand;
    logic              found;

    // Round-robin pick: first set req bit after the previous owner, with wrap
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Saturating ISSUE-cycle count; never wraps back to zero
    always_comb begin
        timer_inc = (timer == TW'(TIMEOUT)) ? timer : timer + TW'(1);
    end

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        last_nxt         = last;
        timer_nxt        = timer;
        xfer_err_r_nxt   = xfer_err_r;
        ack_nxt          = ack;
        xfer_err_nxt     = xfer_err;
        grant_nxt        = grant;
        pg_req_nxt       = pg_req;
        pg_optype_nxt    = pg_optype;
        pg_req_addr_nxt  = pg_req_addr;
        timeout_flag_nxt = timeout_flag;
        case (state)
            IDLE: begin
                if (calib_s && found) begin
                    state_nxt       = ISSUE;
                    owner_nxt       = win;
                    pg_optype_nxt   = req_optype[win];
                    pg_req_addr_nxt = req_addr[32'(win) * ADDR_W +: ADDR_W];
                    grant_nxt       = N_REQ'(1) << win;
                    timer_nxt       = '0;
                    pg_req_nxt      = 1'b1;
                end
            end
            ISSUE: begin
                timer_nxt = timer_inc;
                // A late ack beats a simultaneous expiry
                if (pg_ack_s) begin
                    state_nxt      = RELEASE;
                    pg_req_nxt     = 1'b0;
                    xfer_err_r_nxt = 1'b0;
                end else if (timer_inc == TW'(TIMEOUT)) begin
                    state_nxt        = RELEASE;
                    pg_req_nxt       = 1'b0;
                    xfer_err_r_nxt   = 1'b1;
                    timeout_flag_nxt = 1'b1;
                end
            end
            RELEASE: begin
                if (!pg_ack_s) begin
                    state_nxt    = RESP;
                    ack_nxt      = grant;
                    xfer_err_nxt = xfer_err_r;
                end
            end
            RESP: begin
                if (!req[owner]) begin
                    state_nxt    = IDLE;
                    ack_nxt      = '0;
                    xfer_err_nxt = 1'b0;
                    grant_nxt    = '0;
                    last_nxt     = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            calib_meta   <= 1'b0;
            calib_s      <= 1'b0;
            pg_ack_meta  <= 1'b0;
            pg_ack_s     <= 1'b0;
            owner        <= '0;
            last         <= IW'(N_REQ - 1);
            timer        <= '0;
            xfer_err_r   <= 1'b0;
            ack          <= '0;
            xfer_err     <= 1'b0;
            grant        <= '0;
            pg_req       <= 1'b0;
            pg_optype    <= 1'b0;
            pg_req_addr  <= '0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            calib_meta   <= calib_done;
            calib_s      <= calib_meta;
            pg_ack_meta  <= pg_ack;
            pg_ack_s     <= pg_ack_meta;
            owner        <= owner_nxt;
            last         <= last_nxt;
            timer        <= timer_nxt;
            xfer_err_r   <= xfer_err_r_nxt;
            ack          <= ack_nxt;
            xfer_err     <= xfer_err_nxt;
            grant        <= grant_nxt;
            pg_req       <= pg_req_nxt;
            pg_optype    <= pg_optype_nxt;
            pg_req_addr  <= pg_req_addr_nxt;
            busy         <= busy_nxt;
            timeout_flag <= timeout_flag_nxt;
        end
    end

endmodule

// File: doc/ddr3_pg_arbiter.md
# ddr3_pg_arbiter

- Shares the single DDR3 page-transfer port (pg_req / pg_optype / pg_req_addr / pg_ack) among N_REQ requesters, for example the waveform-buffer writer and the XDOM readout.
- Runs in the system clock domain; the page-transfer port lives in the DDR3 UI-clock domain.
- Arbitrates round-robin and runs a 4-phase handshake on both sides.
- Supplies a one-hot grant so the DPRAM port mux can follow the active transfer, and drops any downstream request that misses its ack timeout.

## Interface

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 28, page address width
- TIMEOUT, 65535, max clk cycles in ISSUE waiting for pg_ack

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- calib_done  in  1  init_calib_complete from the UI-clock domain; double-flop synchronized internally
- req  in  N_REQ  per-requester request level (4-phase)
- req_optype  in  N_REQ  per-requester op type, passed through unchanged
- req_addr  in  N_REQ*ADDR_W  per-requester page address; slice i = [i*ADDR_W +: ADDR_W]
- ack  out  N_REQ  per-requester completion level (4-phase)
- xfer_err  out  1  valid while any ack bit is high; 1 = transfer timed out
- grant  out  N_REQ  one-hot owner of the DPRAM port, 0 when idle
- pg_req  out  1  to page-transfer controller (synchronized on its side)
- pg_optype  out  1  latched op type
- pg_req_addr  out  ADDR_W  latched address
- pg_ack  in  1  from page-transfer controller (UI-clock domain); double-flop synchronized internally to pg_ack_s
- busy  out  1  state != IDLE
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

## Operation

State machine: IDLE, ISSUE, RELEASE, RESP. All outputs are registered.

IDLE:
- Wait for calib_s = 1 and req != 0.
- Winner = first set bit of req, scanning from (last+1) mod N_REQ upward with wrap.
- Latch the winner index, req_optype[w] and req_addr slice w.
- Set grant = 1<<w. Clear the timer. Go to ISSUE.

ISSUE:
- pg_req = 1; the timer increments each cycle.
- pg_ack_s = 1 → pg_req = 0, go to RELEASE, xfer_err_r = 0.
- Timer reaches TIMEOUT with pg_ack_s still 0 → pg_req = 0, xfer_err_r = 1, timeout_flag = 1, go to RELEASE.
- If both conditions occur in the same cycle, the ack wins and no error is flagged.

RELEASE:
- Wait for pg_ack_s = 0, then go to RESP with ack[w] = 1.

RESP:
- ack[w] = 1 and xfer_err = xfer_err_r.
- When req[w] = 0 is sampled: ack = 0, grant = 0, last = w, go to IDLE.

Rules:
- pg_optype and pg_req_addr are latched in IDLE and held from the cycle pg_req rises until the next grant.
- grant stays constant from IDLE exit until RESP exit, covering the whole DDR3↔DPRAM transfer.
- Requests that arrive while not in IDLE are held pending. Requester inputs other than req[w] are ignored until IDLE.
- A requester that drops req before receiving ack is not aborted; the transfer completes and ack pulses for one cycle (req[w] is already 0).
- If calib_done falls while not in IDLE, the current transaction completes normally. No new grant is issued until calib_s = 1.
- Reset mid-operation: all state is cleared immediately. The owner must also reset the page-transfer controller.

## Timing

Reset values:
- All outputs 0, state IDLE.
- last = N_REQ-1, so requester 0 has highest priority after reset.

Latency:
- req[i] rising at edge k (IDLE, calib_s = 1) → grant and pg_req high after edge k+1.
- pg_ack pin edge → pg_ack_s two clk edges later. The state reacts on the following edge.
- pg_ack_s = 1 → pg_req low one edge later.
- pg_ack_s = 0 → ack[w] high one edge later.
- req[w] low → ack[w] and grant low one edge later. A new grant can follow one edge after that (minimum 1 IDLE cycle).

Timeout:
- TIMEOUT counts full clk cycles in ISSUE.
- The timer is ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.

## Test plan

- **Single request:** N_REQ = 2, calib_done = 1, req[0] with addr 0x0000123, optype 1; model acks 10 cycles later. Required: pg_req_addr = 0x0000123, pg_optype = 1, grant = 01, ack[0] high after pg_ack falls, xfer_err = 0.
- **Round-robin fairness:** req[0] and req[1] both held high through three transactions. Required: grant order 01, 10, 01; no back-to-back grants to the same index while the other is pending.
- **Calibration gating:** calib_done = 0 with req[1] = 1 for 100 cycles. Required: pg_req = 0, busy = 0. Raising calib_done → grant = 10 within 4 cycles.
- **Timeout:** TIMEOUT = 20, model never acks. Required:
  - pg_req drops on the 20th ISSUE cycle;
  - ack[0] = 1 with xfer_err = 1;
  - timeout_flag = 1 and stays 1 after the next successful transfer.
- **Boundary:**
  - Ack arriving on the same cycle the timer expires → xfer_err = 0.
  - req[w] dropped before ack → one-cycle ack pulse, then IDLE.
- **Reset mid-transfer:** assert rst_n = 0 while in ISSUE. Required: pg_req, grant, ack, busy and timeout_flag are 0 before the next edge; requester 0 gets the first grant after release.
